// File: rtl/fthread_rd_reorder.sv
// Per-fthread read reorder: stamps local tags on requests and returns responses to the user in issue order.
// Latency: response at edge k appears at the output after edge k+1; no backpressure on responses, usr_rx_ready stalls the drain.
module fthread_rd_reorder #(
    parameter int TAG_WIDTH  = 6,
    parameter int DEPTH      = 64,
    parameter int HDR_WIDTH  = 68,
    parameter int DATA_WIDTH = 512
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          usr_rd_valid,
    input  logic [HDR_WIDTH-TAG_WIDTH-1:0] usr_rd_payload,
    output logic                          usr_rd_ready,
    output logic                          ft_tx_rd_valid,
    output logic [HDR_WIDTH-1:0]          ft_tx_rd_hdr,
    input  logic                          ft_tx_rd_ready,
    input  logic                          ft_rx_rd_valid,
    input  logic [DATA_WIDTH-1:0]         ft_rx_data,
    input  logic [TAG_WIDTH-1:0]          ft_rx_rd_tag,
    output logic                          usr_rx_valid,
    output logic [DATA_WIDTH-1:0]         usr_rx_data,
    input  logic                          usr_rx_ready,
    output logic [TAG_WIDTH:0]            outstanding,
    output logic                          tag_err
);

    localparam int CNT_W = TAG_WIDTH + 1;

    logic [TAG_WIDTH-1:0]  r_iptr;
    logic [TAG_WIDTH-1:0]  r_hptr;
    logic [DEPTH-1:0]      r_vld;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]      r_out_cnt;
    logic                  r_usr_rx_valid;
    logic [DATA_WIDTH-1:0] r_usr_rx_data;
    logic                  r_tag_err;

    logic                  w_full;
    logic                  w_issue;
    logic [TAG_WIDTH-1:0]  w_offs;
    logic                  w_in_win;
    logic                  w_rx_ok;
    logic                  w_rx_bad;
    logic                  w_load;

    assign w_full         = (r_out_cnt == CNT_W'(DEPTH));
    assign ft_tx_rd_valid = usr_rd_valid & ~w_full;
    assign usr_rd_ready   = ft_tx_rd_ready & ~w_full;
    assign ft_tx_rd_hdr   = {usr_rd_payload, r_iptr};
    assign w_issue        = usr_rd_valid & ft_tx_rd_ready & ~w_full;

    // A tag is live iff its distance from the head is below the live count;
    // this also rejects everything when nothing is outstanding.
    assign w_offs   = ft_rx_rd_tag - r_hptr;
    assign w_in_win = ({1'b0, w_offs} < r_out_cnt);
    assign w_rx_ok  = ft_rx_rd_valid & w_in_win & ~r_vld[ft_rx_rd_tag];
    assign w_rx_bad = ft_rx_rd_valid & ~(w_in_win & ~r_vld[ft_rx_rd_tag]);

    assign w_load = (~r_usr_rx_valid | usr_rx_ready) & r_vld[r_hptr];

    always_ff @(posedge clk) begin
        if (w_rx_ok) begin
            r_mem[ft_rx_rd_tag] <= ft_rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iptr         <= '0;
            r_hptr         <= '0;
            r_vld          <= '0;
            r_out_cnt      <= '0;
            r_usr_rx_valid <= 1'b0;
            r_usr_rx_data  <= '0;
            r_tag_err      <= 1'b0;
        end else begin
            if (w_issue) begin
                r_iptr <= r_iptr + TAG_WIDTH'(1);
            end
            // The head entry is already valid when loaded, so a response
            // accepted this cycle always targets a different entry.
            if (w_rx_ok) begin
                r_vld[ft_rx_rd_tag] <= 1'b1;
            end
            if (w_load) begin
                r_vld[r_hptr]  <= 1'b0;
                r_hptr         <= r_hptr + TAG_WIDTH'(1);
                r_usr_rx_data  <= r_mem[r_hptr];
                r_usr_rx_valid <= 1'b1;
            end else if (usr_rx_ready) begin
                r_usr_rx_valid <= 1'b0;
            end
            case ({w_issue, w_load})
                2'b10:   r_out_cnt <= r_out_cnt + CNT_W'(1);
                2'b01:   r_out_cnt <= r_out_cnt - CNT_W'(1);
                default: r_out_cnt <= r_out_cnt;
            endcase
            if (w_rx_bad) begin
                r_tag_err <= 1'b1;
            end
        end
    end

    assign usr_rx_valid = r_usr_rx_valid;
    assign usr_rx_data  = r_usr_rx_data;
    assign outstanding  = r_out_cnt;
    assign tag_err      = r_tag_err;

endmodule

// File: tb/tb_fthread_rd_reorder.sv
// Bench for fthread_rd_reorder: queue-based ordering model checked every cycle, plus directed literal checks.
module tb_fthread_rd_reorder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         usr_rd_valid = 1'b0;
    logic [61:0]  usr_rd_payload = '0;
    logic         usr_rd_ready;
    logic         ft_tx_rd_valid;
    logic [67:0]  ft_tx_rd_hdr;
    logic         ft_tx_rd_ready = 1'b0;
    logic         ft_rx_rd_valid = 1'b0;
    logic [511:0] ft_rx_data = '0;
    logic [5:0]   ft_rx_rd_tag = '0;
    logic         usr_rx_valid;
    logic [511:0] usr_rx_data;
    logic         usr_rx_ready = 1'b0;
    logic [6:0]   outstanding;
    logic         tag_err;

    fthread_rd_reorder dut (
        .clk(clk), .rst_n(rst_n),
        .usr_rd_valid(usr_rd_valid), .usr_rd_payload(usr_rd_payload), .usr_rd_ready(usr_rd_ready),
        .ft_tx_rd_valid(ft_tx_rd_valid), .ft_tx_rd_hdr(ft_tx_rd_hdr), .ft_tx_rd_ready(ft_tx_rd_ready),
        .ft_rx_rd_valid(ft_rx_rd_valid), .ft_rx_data(ft_rx_data), .ft_rx_rd_tag(ft_rx_rd_tag),
        .usr_rx_valid(usr_rx_valid), .usr_rx_data(usr_rx_data), .usr_rx_ready(usr_rx_ready),
        .outstanding(outstanding), .tag_err(tag_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: pend holds issued tags in issue order; arrived data waits in m_mem.
    int           pend[$];
    logic [511:0] m_mem [64];
    bit           m_arr [64];
    int           m_iptr = 0;
    int           m_cnt = 0;
    bit           m_ovld = 0;
    logic [511:0] m_odata = '0;
    bit           m_err = 0;

    function automatic bit in_pend(int tag);
        foreach (pend[i]) if (pend[i] == tag) return 1;
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend.delete();
            for (int i = 0; i < 64; i++) m_arr[i] = 0;
            m_iptr = 0; m_cnt = 0; m_ovld = 0; m_odata = '0; m_err = 0;
        end else begin
            bit d, rok, iss;
            int rt;
            rt  = int'(ft_rx_rd_tag);
            iss = usr_rd_valid && ft_tx_rd_ready && (m_cnt < 64);
            d   = (!m_ovld || usr_rx_ready) && (pend.size() > 0) && m_arr[pend[0]];
            rok = ft_rx_rd_valid && in_pend(rt) && !m_arr[rt];
            if (ft_rx_rd_valid && !rok) m_err = 1;
            if (d) begin
                m_odata = m_mem[pend[0]];
                m_arr[pend[0]] = 0;
                void'(pend.pop_front());
                m_ovld = 1;
                m_cnt--;
            end else if (usr_rx_ready) begin
                m_ovld = 0;
            end
            if (rok) begin
                m_mem[rt] = ft_rx_data;
                m_arr[rt] = 1;
            end
            if (iss) begin
                pend.push_back(m_iptr);
                m_iptr = (m_iptr + 1) % 64;
                m_cnt++;
            end
        end
    end

    logic [511:0] got[$];

    always @(negedge clk) begin
        chk("rx_valid", usr_rx_valid, m_ovld);
        chk("rx_data", usr_rx_data, m_odata);
        chk("outstanding", outstanding, m_cnt);
        chk("tag_err", tag_err, m_err);
        chk("tx_valid", ft_tx_rd_valid, usr_rd_valid && (m_cnt < 64));
        chk("rd_ready", usr_rd_ready, ft_tx_rd_ready && (m_cnt < 64));
        chk("tx_hdr", ft_tx_rd_hdr, {usr_rd_payload, 6'(m_iptr)});
        if (usr_rx_valid && usr_rx_ready) got.push_back(usr_rx_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        usr_rd_valid = 0; ft_tx_rd_ready = 0; ft_rx_rd_valid = 0; usr_rx_ready = 0;
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        tick();
        got.delete();
    endtask

    task automatic issue(input int n);
        ft_tx_rd_ready = 1;
        usr_rd_valid = 1;
        for (int i = 0; i < n; i++) begin
            usr_rd_payload = 62'(i + 1);
            tick();
        end
        usr_rd_valid = 0;
    endtask

    task automatic respond(input int tag, input logic [511:0] d);
        ft_rx_rd_valid = 1;
        ft_rx_rd_tag = 6'(tag);
        ft_rx_data = d;
        tick();
        ft_rx_rd_valid = 0;
    endtask

    function automatic logic [511:0] dval(int t, int i);
        return {64{8'(t * 16 + i)}};
    endfunction

    task automatic cmp_got(input string nm, input logic [511:0] exp_q[$]);
        logic [511:0] a;
        chk({nm, "_len"}, 512'(got.size()), 512'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            a = (i < got.size()) ? got[i] : 'x;
            chk(nm, a, exp_q[i]);
        end
    endtask

    initial begin
        logic [511:0] eq[$];
        int ord[8];
        #1;
        reset_dut();
        chk("rst_outstanding", outstanding, 0);
        chk("rst_rx_valid", usr_rx_valid, 0);
        chk("rst_tag_err", tag_err, 0);

        // 1: single in-order read
        usr_rx_ready = 1; ft_tx_rd_ready = 1;
        usr_rd_payload = 62'h123; usr_rd_valid = 1;
        #1;
        chk("t1_hdr_tag", ft_tx_rd_hdr[5:0], 0);
        chk("t1_hdr_pay", ft_tx_rd_hdr[67:6], 62'h123);
        tick();
        usr_rd_valid = 0;
        repeat (5) tick();
        respond(0, 512'hA5);
        chk("t1_not_yet", usr_rx_valid, 0);
        tick();
        chk("t1_valid", usr_rx_valid, 1);
        chk("t1_data", usr_rx_data, 512'hA5);
        chk("t1_outstanding", outstanding, 0);
        tick();
        eq = {512'hA5};
        cmp_got("t1_seq", eq);

        // 2: reverse-order responses
        reset_dut();
        usr_rx_ready = 1;
        issue(4);
        respond(3, dval(2, 3)); respond(2, dval(2, 2)); respond(1, dval(2, 1));
        tick();
        chk("t2_none_early", usr_rx_valid, 0);
        respond(0, dval(2, 0));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_stream_valid", usr_rx_valid, 1);
            chk("t2_stream_data", usr_rx_data, dval(2, i));
        end
        tick();
        eq = {dval(2, 0), dval(2, 1), dval(2, 2), dval(2, 3)};
        cmp_got("t2_seq", eq);

        // 3: fill all 64 tags, then free one and wrap
        reset_dut();
        issue(64);
        usr_rd_valid = 1;
        #1;
        chk("t3_full_cnt", outstanding, 64);
        chk("t3_full_rdy", usr_rd_ready, 0);
        chk("t3_full_txv", ft_tx_rd_valid, 0);
        tick();
        usr_rd_valid = 0;
        usr_rx_ready = 1;
        respond(0, dval(3, 0));
        tick();
        chk("t3_after_drain", outstanding, 63);
        usr_rd_valid = 1;
        #1;
        chk("t3_wrap_tag", ft_tx_rd_hdr[5:0], 0);
        chk("t3_wrap_txv", ft_tx_rd_valid, 1);
        tick();
        usr_rd_valid = 0;
        chk("t3_refull", outstanding, 64);
        eq = {dval(3, 0)};
        cmp_got("t3_seq", eq);

        // 4: scrambled responses drained under toggling backpressure
        reset_dut();
        issue(8);
        ord = '{7, 5, 3, 1, 0, 2, 4, 6};
        foreach (ord[i]) respond(ord[i], dval(4, ord[i]));
        for (int i = 0; i < 24; i++) begin
            usr_rx_ready = (i % 2 == 0);
            tick();
        end
        usr_rx_ready = 1;
        repeat (4) tick();
        eq.delete();
        for (int i = 0; i < 8; i++) eq.push_back(dval(4, i));
        cmp_got("t4_seq", eq);

        // 5: stray and duplicate responses are flagged and dropped
        reset_dut();
        issue(3);
        respond(5, dval(5, 15));
        chk("t5_err_set", tag_err, 1);
        respond(1, dval(5, 1));
        respond(1, dval(5, 14));
        chk("t5_err_hold", tag_err, 1);
        respond(0, dval(5, 0));
        respond(2, dval(5, 2));
        usr_rx_ready = 1;
        repeat (6) tick();
        chk("t5_err_sticky", tag_err, 1);
        eq = {dval(5, 0), dval(5, 1), dval(5, 2)};
        cmp_got("t5_seq", eq);

        // 6: asynchronous reset with work in flight
        reset_dut();
        issue(11);
        respond(0, dval(6, 0));
        tick();
        chk("t6_pre_valid", usr_rx_valid, 1);
        chk("t6_pre_cnt", outstanding, 10);
        #1 rst_n = 0;
        #1;
        chk("t6_rst_cnt", outstanding, 0);
        chk("t6_rst_valid", usr_rx_valid, 0);
        tick(); tick();
        rst_n = 1;
        usr_rd_valid = 1;
        #1;
        chk("t6_tag0", ft_tx_rd_hdr[5:0], 0);
        tick();
        usr_rd_valid = 0;
        chk("t6_cnt1", outstanding, 1);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fthread_rd_reorder.md
Name: fthread_rd_reorder

Overview:
- Per-fthread read-side stage that sits directly upstream of the channel data arbiter on one fthread's read port.
- Allocates local read tags and stamps them into outgoing read headers.
- Accepts the arbiter's out-of-order read responses (data plus local tag) into a tag-indexed reorder buffer.
- Returns the read data to the fthread user logic strictly in request order, with valid/ready backpressure.

Parameters:
- TAG_WIDTH, 6: local tag width; equals the codebase's per-fthread tag width.
- DEPTH, 64: reorder buffer entries; must equal 2**TAG_WIDTH.
- HDR_WIDTH, 68: width of the read header sent to the arbiter.
- DATA_WIDTH, 512: cache-line width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- usr_rd_valid  in  1  user read request valid
- usr_rd_payload  in  HDR_WIDTH-TAG_WIDTH  request header without tag (address/attributes)
- usr_rd_ready  out  1  request accepted this cycle when high with usr_rd_valid
- ft_tx_rd_valid  out  1  request to arbiter
- ft_tx_rd_hdr  out  HDR_WIDTH  {usr_rd_payload, tag}; tag in bits [TAG_WIDTH-1:0]
- ft_tx_rd_ready  in  1  arbiter accepts request
- ft_rx_rd_valid  in  1  read response from arbiter
- ft_rx_data  in  DATA_WIDTH  response data
- ft_rx_rd_tag  in  TAG_WIDTH  response tag
- usr_rx_valid  out  1  in-order data valid
- usr_rx_data  out  DATA_WIDTH  in-order data
- usr_rx_ready  in  1  user consumes data
- outstanding  out  TAG_WIDTH+1  entries allocated and not yet handed to the output register
- tag_err  out  1  sticky protocol error flag

Behaviour:
- Reset (async assert, sync release):
  - usr_rx_valid=0, usr_rx_data=0, tag_err=0, outstanding=0.
  - Issue pointer iptr=0, head pointer hptr=0, all entry-valid bits cleared.
  - Any reset mid-operation discards all in-flight state; responses arriving afterwards are handled by the error rules below.
- Request path (combinational):
  - full = (outstanding==DEPTH).
  - ft_tx_rd_valid = usr_rd_valid & ~full.
  - usr_rd_ready = ft_tx_rd_ready & ~full.
  - ft_tx_rd_hdr = {usr_rd_payload, iptr[TAG_WIDTH-1:0]}.
  - Issue occurs when ft_tx_rd_valid & ft_tx_rd_ready; iptr increments modulo DEPTH (wraps 63->0).
  - No request is issued while full, even if ft_tx_rd_ready is high.
- Response capture:
  - On ft_rx_rd_valid, write ft_rx_data into entry ft_rx_rd_tag and set its valid bit at the same edge.
  - One response accepted per cycle; there is no backpressure on this path.
- Drain:
  - Output register loads when (~usr_rx_valid | usr_rx_ready) and valid[hptr]==1.
  - On load: usr_rx_data<=entry[hptr], usr_rx_valid<=1, valid[hptr]<=0, hptr++ modulo DEPTH.
  - If no load and usr_rx_ready is high, usr_rx_valid<=0.
  - Minimum latency: a response sampled at edge k for the head tag makes usr_rx_valid high after edge k+1.
  - Sustained throughput is 1 line/cycle while the head is ready and usr_rx_ready is held high.
- Counting:
  - outstanding increments on issue and decrements on output-register load.
  - Issue and load in the same cycle leave it unchanged.
  - An entry freed by a load is reusable by an issue in the following cycle, not the same cycle.
- Simultaneous response and drain on the same tag in one cycle cannot occur: a tag is drained only after its valid bit is set.
- Error rules:
  - tag_err sets, and stays set until reset, on a response whose tag is not outstanding (outside the window [hptr, iptr) modulo DEPTH, or outstanding==0) or whose entry valid bit is already set.
  - The offending response is dropped and the entry is left unchanged.
- Ordering guarantee: usr_rx_data order equals issue order regardless of response order.

Test Plan:
1. In-order single read: issue 1 request with payload 0x123, respond with tag 0 and data 0xA5 after 5 cycles, usr_rx_ready=1 -> ft_tx_rd_hdr low 6 bits = 0; usr_rx_data=0xA5 two edges after the response; outstanding returns to 0.
2. Reverse order: issue tags 0..3, respond 3,2,1,0 with data D3..D0 -> output D0,D1,D2,D3 on 4 consecutive cycles right after tag 0 arrives; nothing is output before then.
3. Full/wrap: issue 64 requests with no responses -> outstanding=64 and usr_rd_ready=0 despite ft_tx_rd_ready=1. Respond with tag 0 and drain it -> next request carries tag 0 (iptr wrapped) and outstanding peaks at 64 again.
4. Backpressure: 8 responses buffered, usr_rx_ready toggled 1/0 -> no data is lost or duplicated, usr_rx_data is held stable while usr_rx_valid=1 and usr_rx_ready=0, order is preserved.
5. Error: respond with tag 5 when only tags 0..2 are outstanding, then repeat a response on tag 1 -> tag_err=1 after the first, stays 1; buffer contents and output sequence are unaffected.
6. Reset mid-operation: assert rst_n=0 asynchronously with 10 outstanding -> usr_rx_valid=0 and outstanding=0 immediately; after release, the next request carries tag 0.
